frame_parser: RTL and testbench
===============================

# frame_parser

Parametrised byte-stream frame parser: the next generation of the team's message identification block. It hunts for a two-byte sync pattern, then delimits type, optional length, payload and FCS fields, and forwards each frame with start, end and valid markers. Additions over the previous generation:
- an input valid qualifier;
- configurable sync bytes, default length, FCS length and maximum length;
- length validation with an error/abort path;
- a good-frame counter.

It sits between the byte deserialiser and downstream frame consumers.

## Interface
Parameters:
- SYNC0, 8'h55, first sync byte
- SYNC1, 8'hD5, second sync byte; final byte of the preamble
- DEF_LEN, 64, payload length used when the type byte is 0 (control frame)
- FCS_LEN, 4, number of FCS bytes (1..255)
- MAX_LEN, 1500, largest legal payload length for data frames
- LEN_W, 16, width of the length field and payload counter (DEF_LEN, MAX_LEN < 2^LEN_W)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  8  input byte
- din_vld  in  1  din qualifier; cycles with din_vld=0 are ignored entirely
- dout  out  8  forwarded byte, registered
- dout_vld  out  1  dout carries a frame byte (type, length, payload or FCS)
- dout_sop  out  1  dout is the type byte (first forwarded byte)
- dout_eop  out  1  dout is the last byte of the frame (normal or aborted)
- dout_err  out  1  asserted together with dout_eop when the frame is aborted
- frame_cnt  out  16  count of frames ended without error; wraps at 16'hFFFF→0

## Operation
- States: HUNT, TYPE, LEN, DATA, FCS. Reset state is HUNT. State, counter and sync history advance only on din_vld=1.
- HUNT:
  - prev register holds the last valid byte.
  - Go to TYPE when din==SYNC1 and prev==SYNC0.
  - Sync bytes are not forwarded.
- TYPE: forward the byte with sop.
  - din==0: set payload length N=DEF_LEN and go to DATA.
  - otherwise: go to LEN.
- LEN: two bytes, big-endian; first byte → N[15:8], second → N[7:0] (LEN_W=16; for other widths the low LEN_W bits of the 16-bit field are used).
  - On the second byte, if N==0 or N>MAX_LEN: abort. That byte is forwarded with eop=1 and err=1, and the next state is HUNT.
  - Otherwise go to DATA.
- DATA: forward N bytes, counter 0..N-1, then go to FCS.
- FCS: forward FCS_LEN bytes. The last one has eop=1 and err=0, frame_cnt increments, and the next state is HUNT.
- prev is cleared to 0 on every entry into HUNT. Sync pattern bytes at the end of a frame therefore cannot combine with bytes of the next frame; a new frame needs both sync bytes to arrive after the frame ends.
- Sync detection is inactive outside HUNT. SYNC bytes inside fields are plain data.
- Counter clears on every field change and on abort. Counter width LEN_W; compare N-1 with no overflow (N≥1 guaranteed).

## Timing
- Reset values: dout=8'h00, dout_vld=0, dout_sop=0, dout_eop=0, dout_err=0, frame_cnt=0, prev=0, counter=0, state HUNT.
- Latency: a byte accepted at edge k appears on dout with its markers after edge k (1 cycle).
- Marker registers (dout_vld, sop, eop, err) are updated every cycle. dout_vld=0 in any cycle after din_vld=0; dout holds its last value.
- sop and eop are never high together, because a frame is at least 1 type byte + 2 length bytes or 1+N+FCS_LEN.
- frame_cnt updates on the same edge that registers the good eop.
- Reset asserted mid-frame: immediate return to reset values. No eop is emitted for the truncated frame.
- din_vld gaps anywhere, including between SYNC0 and SYNC1, do not break detection or counting.

## Test plan
- Control frame: 55 D5 00, 64 payload bytes 0x00..0x3F, FCS A1 B2 C3 D4, all din_vld=1. Required:
  - 69 dout_vld cycles;
  - sop on 00;
  - eop on D4 with err=0;
  - frame_cnt=1.
- Data frame with length: 55 D5 01 00 03 11 22 33, FCS 4 bytes. Required: 10 forwarded bytes, eop on the 10th, frame_cnt increments.
- Gapped input: same data frame with din_vld=0 every other cycle, including between 55 and D5. Required: output identical in content and markers, only spread in time.
- Length error: 55 D5 07 00 00, then separately 55 D5 07 05 DD (1501 > MAX_LEN). Required for each:
  - eop+err on the second length byte;
  - return to HUNT; the following bytes are not forwarded;
  - frame_cnt unchanged.
- False syncs: stream 55 55 AA D5 55 D5 01 00 01 D5 D5 + FCS. Required:
  - frame starts only after the 55 D5 pair;
  - D5 inside the payload is forwarded as data;
  - a frame ending in FCS byte 55 followed by D5 does not resync.
- Reset mid-DATA, then a clean control frame. Required: all outputs 0 during reset; the next frame parses normally with frame_cnt counting from 0.

Source files
------------

// File: rtl/frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : frame_parser
//  Description : Byte-stream frame parser. Hunts for a two-byte sync pattern
//                (SYNC0, SYNC1), then delimits the type byte, an optional
//                two-byte big-endian length, the payload and the FCS. Each
//                forwarded byte is registered with valid/start/end/error
//                markers. Frames with an illegal length are aborted on the
//                second length byte. Frames that end without error are
//                counted in frame_cnt.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                din        - input byte
//                din_vld    - din qualifier; cycles with din_vld=0 are ignored
//                dout       - forwarded byte (holds its value when idle)
//                dout_vld   - dout carries a frame byte
//                dout_sop   - dout is the type byte
//                dout_eop   - dout is the last byte of the frame
//                dout_err   - with dout_eop: the frame was aborted
//                frame_cnt  - count of frames ended without error (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_parser #(
    parameter logic [7:0] SYNC0   = 8'h55,
    parameter logic [7:0] SYNC1   = 8'hD5,
    parameter int         DEF_LEN = 64,
    parameter int         FCS_LEN = 4,
    parameter int         MAX_LEN = 1500,
    parameter int         LEN_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_err,
    output logic [15:0] frame_cnt
);

    localparam logic [LEN_W-1:0] C_DEF_LEN  = LEN_W'(DEF_LEN);
    localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] C_FCS_LAST = LEN_W'(FCS_LEN - 1);

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_TYPE = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_FCS  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_prev;
    logic [7:0]         w_prev_nxt;
    logic [7:0]         r_len_hi;
    logic [7:0]         w_len_hi_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_len_rx;
    logic               w_fwd;
    logic               w_sop;
    logic               w_eop;
    logic               w_err;
    logic               w_good;

    // Length as it stands once the second length byte arrives; only the low
    // LEN_W bits of the 16-bit field are significant.
    assign w_len_rx = LEN_W'({r_len_hi, din});

    // ------------------------------------------------------------------
    // State register and parser context
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HUNT;
            r_prev   <= 8'h00;
            r_len_hi <= 8'h00;
            r_len    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_prev   <= w_prev_nxt;
            r_len_hi <= w_len_hi_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and marker decode. Nothing moves on din_vld=0 cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_len_hi_nxt = r_len_hi;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_fwd        = 1'b0;
        w_sop        = 1'b0;
        w_eop        = 1'b0;
        w_err        = 1'b0;
        w_good       = 1'b0;

        if (din_vld) begin
            case (r_state)
                S_HUNT: begin
                    w_prev_nxt = din;
                    if (din == SYNC1 && r_prev == SYNC0) begin
                        w_state_nxt = S_TYPE;
                        w_cnt_nxt   = '0;
                    end
                end

                S_TYPE: begin
                    w_fwd     = 1'b1;
                    w_sop     = 1'b1;
                    w_cnt_nxt = '0;
                    if (din == 8'h00) begin
                        w_len_nxt   = C_DEF_LEN;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_LEN;
                    end
                end

                S_LEN: begin
                    w_fwd = 1'b1;
                    if (r_cnt == '0) begin
                        w_len_hi_nxt = din;
                        w_cnt_nxt    = r_cnt + 1'b1;
                    end else begin
                        w_cnt_nxt = '0;
                        if (w_len_rx == '0 || w_len_rx > C_MAX_LEN) begin
                            // Abort: close the frame on this byte with err.
                            w_eop       = 1'b1;
                            w_err       = 1'b1;
                            w_state_nxt = S_HUNT;
                            w_prev_nxt  = 8'h00;
                        end else begin
                            w_len_nxt   = w_len_rx;
                            w_state_nxt = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    w_fwd = 1'b1;
                    // r_len is at least 1 here, so r_len-1 cannot wrap.
                    if (r_cnt == r_len - 1'b1) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FCS;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                S_FCS: begin
                    w_fwd = 1'b1;
                    if (r_cnt == C_FCS_LAST) begin
                        w_eop       = 1'b1;
                        w_good      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HUNT;
                        // Clearing prev stops a trailing SYNC0 in the FCS
                        // from pairing with a SYNC1 after the frame.
                        w_prev_nxt  = 8'h00;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = S_HUNT;
                    w_prev_nxt  = 8'h00;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers: markers refresh every cycle, dout only on forward.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= 8'h00;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout_err  <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            dout_vld <= w_fwd;
            dout_sop <= w_sop;
            dout_eop <= w_eop;
            dout_err <= w_err;
            if (w_fwd) begin
                dout <= din;
            end
            if (w_good) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_parser
//  Description : Directed self-checking bench for frame_parser. A monitor
//                records every forwarded byte with its markers and the cycle
//                it appeared in; each test task drives a hand-written byte
//                stream and compares the record against hand-computed bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       err;
        int         cyc;
    } rec_t;

    rec_t       q[$];
    logic [7:0] stim[$];
    logic [7:0] exp_d[$];

    frame_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout_err  (dout_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dout_vld === 1'b1) begin
            q.push_back('{d: dout, sop: dout_sop, eop: dout_eop, err: dout_err, cyc: cyc});
        end
    end

    // Drive stim[] byte by byte; optional idle (din_vld=0) cycle after each
    // byte carrying SYNC1 on din to show that idle cycles are ignored.
    task automatic drive(input bit gapped);
        foreach (stim[i]) begin
            @(negedge clk);
            din     = stim[i];
            din_vld = 1'b1;
            if (gapped) begin
                @(negedge clk);
                din     = 8'hD5;
                din_vld = 1'b0;
            end
        end
        @(negedge clk);
        din     = 8'h00;
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic build_control_frame();
        stim  = {8'h55, 8'hD5, 8'h00};
        exp_d = {8'h00};
        for (int i = 0; i < 64; i++) begin
            stim.push_back(8'(i));
            exp_d.push_back(8'(i));
        end
        stim  = {stim, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_d = {exp_d, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, dout_err, frame_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset_values: got dout=%h vld=%b sop=%b eop=%b err=%b cnt=%0d, expected all zero",
                     dout, dout_vld, dout_sop, dout_eop, dout_err, frame_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_control_frame();
        q = {};
        build_control_frame();
        drive(1'b0);
        checks++;
        if (q.size() != 69) begin
            errors++;
            $display("FAIL ctrl_count: got %0d bytes, expected 69", q.size());
        end
        for (int i = 0; i < q.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q[i].d !== exp_d[i] || q[i].sop !== (i == 0) ||
                q[i].eop !== (i == exp_d.size() - 1) || q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL ctrl_byte[%0d]: got d=%h sop=%b eop=%b err=%b, expected d=%h sop=%b eop=%b err=0",
                         i, q[i].d, q[i].sop, q[i].eop, q[i].err, exp_d[i], (i == 0), (i == exp_d.size() - 1));
                break;
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ctrl_frame_cnt: got %0d, expected 1", frame_cnt);
        end
    endtask

    // Shared by the plain and the gapped variant; gapped output must also be
    // spread one byte every two cycles.
    task automatic test_data_frame(input bit gapped, input logic [15:0] cnt_exp);
        q     = {};
        stim  = {8'h55, 8'hD5, 8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33,
                 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        exp_d = {8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        drive(gapped);
        checks++;
        if (q.size() != 10) begin
            errors++;
            $display("FAIL data_count(gap=%0d): got %0d bytes, expected 10", gapped, q.size());
        end
        for (int i = 0; i < q.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q[i].d !== exp_d[i] || q[i].sop !== (i == 0) ||
                q[i].eop !== (i == 9) || q[i].err !== 1'b0 ||
                (i > 0 && (q[i].cyc - q[i-1].cyc) != (gapped ? 2 : 1))) begin
                errors++;
                $display("FAIL data_byte[%0d](gap=%0d): got d=%h sop=%b eop=%b err=%b, expected d=%h sop=%b eop=%b err=0 at spacing %0d",
                         i, gapped, q[i].d, q[i].sop, q[i].eop, q[i].err, exp_d[i], (i == 0), (i == 9), gapped ? 2 : 1);
                break;
            end
        end
        checks++;
        if (frame_cnt !== cnt_exp) begin
            errors++;
            $display("FAIL data_frame_cnt(gap=%0d): got %0d, expected %0d", gapped, frame_cnt, cnt_exp);
        end
    endtask

    task automatic test_len_error();
        for (int c = 0; c < 2; c++) begin
            q = {};
            if (c == 0) begin
                stim  = {8'h55, 8'hD5, 8'h07, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
                exp_d = {8'h07, 8'h00, 8'h00};
            end else begin
                stim  = {8'h55, 8'hD5, 8'h07, 8'h05, 8'hDD, 8'h44, 8'h55, 8'h66};
                exp_d = {8'h07, 8'h05, 8'hDD};
            end
            drive(1'b0);
            checks++;
            if (q.size() != 3) begin
                errors++;
                $display("FAIL lenerr_count[%0d]: got %0d bytes, expected 3", c, q.size());
            end
            for (int i = 0; i < q.size() && i < 3; i++) begin
                checks++;
                if (q[i].d !== exp_d[i] || q[i].sop !== (i == 0) ||
                    q[i].eop !== (i == 2) || q[i].err !== (i == 2)) begin
                    errors++;
                    $display("FAIL lenerr_byte[%0d][%0d]: got d=%h sop=%b eop=%b err=%b, expected d=%h sop=%b eop=%b err=%b",
                             c, i, q[i].d, q[i].sop, q[i].eop, q[i].err, exp_d[i], (i == 0), (i == 2), (i == 2));
                    break;
                end
            end
            checks++;
            if (frame_cnt !== 16'd3) begin
                errors++;
                $display("FAIL lenerr_frame_cnt[%0d]: got %0d, expected 3", c, frame_cnt);
            end
        end
    endtask

    task automatic test_false_sync();
        q     = {};
        stim  = {8'h55, 8'h55, 8'hAA, 8'hD5, 8'h55, 8'hD5, 8'h01, 8'h00, 8'h01,
                 8'hD5, 8'hD5, 8'h10, 8'h20, 8'h55, 8'hD5, 8'h01, 8'h00, 8'h01, 8'hAA};
        exp_d = {8'h01, 8'h00, 8'h01, 8'hD5, 8'hD5, 8'h10, 8'h20, 8'h55};
        drive(1'b0);
        checks++;
        if (q.size() != 8) begin
            errors++;
            $display("FAIL fsync_count: got %0d bytes, expected 8", q.size());
        end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            checks++;
            if (q[i].d !== exp_d[i] || q[i].sop !== (i == 0) ||
                q[i].eop !== (i == 7) || q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL fsync_byte[%0d]: got d=%h sop=%b eop=%b err=%b, expected d=%h sop=%b eop=%b err=0",
                         i, q[i].d, q[i].sop, q[i].eop, q[i].err, exp_d[i], (i == 0), (i == 7));
                break;
            end
        end
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL fsync_frame_cnt: got %0d, expected 4", frame_cnt);
        end
    endtask

    // Length exactly MAX_LEN (0x05DC) must be accepted.
    task automatic test_max_len();
        int n_err;
        q     = {};
        stim  = {8'h55, 8'hD5, 8'h02, 8'h05, 8'hDC};
        exp_d = {8'h02, 8'h05, 8'hDC};
        for (int i = 0; i < 1500; i++) begin
            stim.push_back(8'(i * 7));
            exp_d.push_back(8'(i * 7));
        end
        stim  = {stim, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        exp_d = {exp_d, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        drive(1'b0);
        checks++;
        if (q.size() != 1507) begin
            errors++;
            $display("FAIL maxlen_count: got %0d bytes, expected 1507", q.size());
        end
        n_err = 0;
        for (int i = 0; i < q.size() && i < exp_d.size(); i++) begin
            if (q[i].d !== exp_d[i] || q[i].sop !== (i == 0) ||
                q[i].eop !== (i == 1506) || q[i].err !== 1'b0) begin
                if (n_err == 0) begin
                    $display("FAIL maxlen_byte[%0d]: got d=%h sop=%b eop=%b err=%b, expected d=%h sop=%b eop=%b err=0",
                             i, q[i].d, q[i].sop, q[i].eop, q[i].err, exp_d[i], (i == 0), (i == 1506));
                end
                n_err++;
            end
        end
        checks++;
        if (n_err != 0) begin
            errors++;
            $display("FAIL maxlen_content: got %0d bad bytes, expected 0", n_err);
        end
        checks++;
        if (frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL maxlen_frame_cnt: got %0d, expected 5", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_eop;
        q    = {};
        stim = {8'h55, 8'hD5, 8'h00};
        for (int i = 0; i < 10; i++) stim.push_back(8'(8'h80 + i));
        drive(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, dout_err, frame_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL midreset_values: got dout=%h vld=%b sop=%b eop=%b err=%b cnt=%0d, expected all zero",
                     dout, dout_vld, dout_sop, dout_eop, dout_err, frame_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_eop = 0;
        foreach (q[i]) if (q[i].eop) n_eop++;
        checks++;
        if (q.size() != 11 || n_eop != 0) begin
            errors++;
            $display("FAIL midreset_truncated: got %0d bytes with %0d eop, expected 11 bytes with 0 eop", q.size(), n_eop);
        end
        q = {};
        build_control_frame();
        drive(1'b0);
        checks++;
        if (q.size() != 69) begin
            errors++;
            $display("FAIL midreset_ctrl_count: got %0d bytes, expected 69", q.size());
        end
        for (int i = 0; i < q.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q[i].d !== exp_d[i] || q[i].sop !== (i == 0) ||
                q[i].eop !== (i == 68) || q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL midreset_ctrl_byte[%0d]: got d=%h sop=%b eop=%b err=%b, expected d=%h sop=%b eop=%b err=0",
                         i, q[i].d, q[i].sop, q[i].eop, q[i].err, exp_d[i], (i == 0), (i == 68));
                break;
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midreset_frame_cnt: got %0d, expected 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_control_frame();
        test_data_frame(1'b0, 16'd2);
        test_data_frame(1'b1, 16'd3);
        test_len_error();
        test_false_sync();
        test_max_len();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
